byte_decode_ctrl: RTL and testbench

Sequential front end for ByteDecode in the Kyber-768-90s datapath. Takes a serial byte stream on a valid/ready handshake and unpacks it LSB-first into NUM_COEFFS coefficients of runtime-selected width ell, one per cycle. A `start` pulse schedules each polynomial and a `done` pulse closes it. It replaces the wide 32·ell-byte combinational array with a small bit accumulator, for use between the hash/XOF byte stream and the NTT coefficient memory.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/byte_decode_ctrl_if.sv | 28 ++
 rtl/byte_decode_ctrl.sv | 108 ++++++++++
 tb/tb_byte_decode_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the legal coefficient-width check used by the
// ByteDecode front end.
package kyber_pkg;

    localparam int unsigned KYBER_N = 256;
    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned MAX_ELL = 12;
    localparam int unsigned BUF_W   = MAX_ELL + 8;

    function automatic logic ell_legal(input logic [3:0] ell);
        case (ell)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: ell_legal = 1'b1;
            default:                               ell_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_decode_ctrl_if.sv
// Control, byte-stream and coefficient-stream signals of byte_decode_ctrl.
// The master drives requests and data; the slave is the decoder.
interface byte_decode_ctrl_if;
    import kyber_pkg::*;

    logic               start;
    logic [3:0]         ell;
    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               out_valid;
    logic [MAX_ELL-1:0] out_coeff;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, ell, in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_coeff, busy, done, err
    );

    modport slave (
        input  start, ell, in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_coeff, busy, done, err
    );

endinterface

// File: rtl/byte_decode_ctrl.sv
// Serial ByteDecode front end: unpacks an LSB-first byte stream into
// NUM_COEFFS coefficients of width ell through a small bit accumulator.
module byte_decode_ctrl
    import kyber_pkg::*;
#(
    parameter int unsigned NUM_COEFFS = KYBER_N
) (
    input  logic                clk,
    input  logic                rst,
    byte_decode_ctrl_if.slave   bus
);

    localparam int unsigned FILL_W = $clog2(BUF_W + 1);
    localparam int unsigned BL_W   = $clog2(32 * MAX_ELL + 1);
    localparam int unsigned CNT_W  = $clog2(NUM_COEFFS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } decode_state_e;

    decode_state_e      r_state;
    decode_state_e      w_next;

    logic [3:0]         r_ell;
    logic [BUF_W-1:0]   r_buf;
    logic [FILL_W-1:0]  r_fill;
    logic [BL_W-1:0]    r_bytes_left;
    logic [CNT_W-1:0]   r_coeffs_left;
    logic               r_err;

    logic               w_run;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_emit;
    logic               w_start_ok;
    logic               w_start_bad;
    logic [BUF_W-1:0]   w_ins;
    logic [MAX_ELL-1:0] w_mask;

    assign w_run       = (r_state == RUN);
    assign w_in_ready  = w_run && (r_fill < FILL_W'(r_ell)) && (r_bytes_left != '0);
    assign w_out_valid = w_run && (r_fill >= FILL_W'(r_ell));
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_emit      = w_out_valid && bus.out_ready;
    assign w_start_ok  = (r_state == IDLE) && bus.start && ell_legal(bus.ell);
    assign w_start_bad = (r_state == IDLE) && bus.start && !ell_legal(bus.ell);

    // fill < ell <= 12 whenever a byte is accepted, so the byte lands below bit 20
    assign w_ins  = BUF_W'(bus.in_byte) << r_fill;
    assign w_mask = ~({MAX_ELL{1'b1}} << r_ell);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_coeff = w_run ? (r_buf[MAX_ELL-1:0] & w_mask) : '0;
    assign bus.busy      = w_run;
    assign bus.done      = (r_state == DONE);
    assign bus.err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start_ok) w_next = RUN;
            RUN:  if (w_emit && (r_coeffs_left == CNT_W'(1))) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ell         <= '0;
            r_buf         <= '0;
            r_fill        <= '0;
            r_bytes_left  <= '0;
            r_coeffs_left <= '0;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_ell         <= bus.ell;
                r_buf         <= '0;
                r_fill        <= '0;
                r_bytes_left  <= BL_W'({bus.ell, 5'b0});
                r_coeffs_left <= CNT_W'(NUM_COEFFS);
            end else if (w_accept) begin
                r_buf        <= r_buf | w_ins;
                r_fill       <= r_fill + FILL_W'(8);
                r_bytes_left <= r_bytes_left - BL_W'(1);
            end else if (w_emit) begin
                r_buf         <= r_buf >> r_ell;
                r_fill        <= r_fill - FILL_W'(r_ell);
                r_coeffs_left <= r_coeffs_left - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_decode_ctrl.sv
// Directed and stalled-stream bench for byte_decode_ctrl with a bit-queue
// reference model feeding an expected-coefficient scoreboard.
module tb_byte_decode_ctrl;
    import kyber_pkg::*;

    localparam int unsigned NC     = KYBER_N;
    localparam int unsigned BUDGET = 20000;

    logic clk = 1'b0;
    logic rst;

    byte_decode_ctrl_if bus ();

    byte_decode_ctrl #(.NUM_COEFFS(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned        vectors     = 0;
    int unsigned        miscompares = 0;
    logic [7:0]         stream[$];
    bit                 bitq[$];
    logic [MAX_ELL-1:0] expq[$];
    logic [MAX_ELL-1:0] first_obs[8];
    int unsigned        n_emitted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_coeff"}, 32'(bus.out_coeff), 32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_err"},       32'(bus.err),       32'd0);
    endtask

    task automatic make_stream(input int unsigned e);
        stream.delete();
        stream.push_back(8'h49);
        stream.push_back(8'h8B);
        stream.push_back(8'h0B);
        for (int unsigned i = 3; i < 32 * e; i++)
            stream.push_back(8'($urandom_range(255)));
    endtask

    task automatic model_push(input logic [7:0] b, input int unsigned e);
        logic [MAX_ELL-1:0] c;
        for (int unsigned j = 0; j < 8; j++) bitq.push_back(b[j]);
        while (bitq.size() >= e) begin
            c = '0;
            for (int unsigned k = 0; k < e; k++) c[k] = bitq.pop_front();
            expq.push_back(c);
        end
    endtask

    task automatic try_bad(input logic [3:0] e);
        bus.start = 1'b1;
        bus.ell   = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("err_pulse",    32'(bus.err),      32'd1);
        check("err_busy",     32'(bus.busy),     32'd0);
        check("err_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("err_drop",     32'(bus.err),      32'd0);
        check("err_idle",     32'(bus.busy),     32'd0);
    endtask

    task automatic begin_poly(input int unsigned e);
        bus.start = 1'b1;
        bus.ell   = 4'(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_busy",      32'(bus.busy),      32'd1);
        check("start_in_ready",  32'(bus.in_ready),  32'd1);
        check("start_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Runs one polynomial from RUN; stop_at != 0 returns after that many emits.
    task automatic run_poly(input int unsigned e, input int unsigned stall,
                            input int unsigned stop_at, input bit poke);
        int unsigned        idx   = 0;
        int unsigned        cyc   = 0;
        int unsigned        early = 0;
        bit                 fin   = 1'b0;
        logic               prev_stall = 1'b0;
        logic [MAX_ELL-1:0] prev_coeff = '0;
        logic [MAX_ELL-1:0] exp_c;
        bitq.delete();
        expq.delete();
        n_emitted = 0;
        while (!fin && cyc < BUDGET) begin
            bus.start     = poke && (cyc == 5);
            bus.ell       = (poke && cyc == 5) ? 4'd4 : 4'(e);
            bus.in_valid  = (idx < stream.size()) && ($urandom_range(99) >= stall);
            bus.in_byte   = (idx < stream.size()) ? stream[idx] : 8'hA5;
            bus.out_ready = ($urandom_range(99) >= stall);
            @(negedge clk);
            check("excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.done) early++;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_coeff", 32'(bus.out_coeff), 32'(prev_coeff));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_coeff = bus.out_coeff;
            if (bus.in_valid && bus.in_ready) begin
                model_push(stream[idx], e);
                idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(expq.size() > 0), 32'd1);
                exp_c = (expq.size() > 0) ? expq.pop_front() : '0;
                check("coeff", 32'(bus.out_coeff), 32'(exp_c));
                if (n_emitted < 8) first_obs[n_emitted] = bus.out_coeff;
                n_emitted++;
                if (n_emitted == NC || n_emitted == stop_at) fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        if (stop_at == 0) begin
            check("emits",        n_emitted,            NC);
            check("bytes_used",   idx,                  32 * e);
            check("done_early",   early,                32'd0);
            check("done_pulse",   32'(bus.done),        32'd1);
            check("busy_at_done", 32'(bus.busy),        32'd0);
            check("fill_at_done", 32'(dut.r_fill),      32'd0);
            check("sb_empty",     expq.size(),          32'd0);
            @(posedge clk); #1;
            check("done_drop",    32'(bus.done),        32'd0);
            check("idle_ready",   32'(bus.in_ready),    32'd0);
        end else begin
            check("partial_emits", n_emitted, stop_at);
        end
    endtask

    logic [MAX_ELL-1:0] exp_e1[8];

    initial begin
        exp_e1 = '{12'd1, 12'd0, 12'd0, 12'd1, 12'd0, 12'd0, 12'd1, 12'd0};
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.ell       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        try_bad(4'd7);
        try_bad(4'd8);
        try_bad(4'd0);
        try_bad(4'd13);

        // ell=12, no stalls, a stray start mid-run must not disturb the decode
        make_stream(12);
        begin_poly(12);
        run_poly(12, 0, 0, 1'b1);
        check("e12_c0", 32'(first_obs[0]), 32'h0B49);
        check("e12_c1", 32'(first_obs[1]), 32'h00B8);

        make_stream(1);
        begin_poly(1);
        run_poly(1, 0, 0, 1'b0);
        for (int unsigned i = 0; i < 8; i++)
            check("e1_bits", 32'(first_obs[i]), 32'(exp_e1[i]));

        make_stream(4);
        begin_poly(4);
        run_poly(4, 0, 0, 1'b0);
        check("e4_c0", 32'(first_obs[0]), 32'd9);
        check("e4_c1", 32'(first_obs[1]), 32'd4);

        make_stream(10);
        begin_poly(10);
        run_poly(10, 40, 0, 1'b0);

        make_stream(5);
        begin_poly(5);
        run_poly(5, 20, 0, 1'b0);

        make_stream(11);
        begin_poly(11);
        run_poly(11, 20, 0, 1'b1);

        make_stream(12);
        begin_poly(12);
        run_poly(12, 10, 100, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_fill", 32'(dut.r_fill), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        make_stream(12);
        begin_poly(12);
        run_poly(12, 25, 0, 1'b0);
        check("post_rst_c0", 32'(first_obs[0]), 32'h0B49);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
